// File: rtl/any1_ialign_buf.sv
// Two-slot instruction aligner between the I-cache line port and decode.
// Extracts fixed-size instructions that may straddle a line boundary into a valid/ready output register.
module any1_ialign_buf #(
  parameter int              LINE_BYTES = 64,
  parameter int              INSN_BYTES = 5,
  parameter int              IP_W       = 32,
  parameter logic [IP_W-1:0] RST_IP     = 32'hFFFC0100
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    line_v,
  output logic                    line_rdy,
  input  logic [IP_W-1:0]         line_adr,
  input  logic [LINE_BYTES*8-1:0] line_data,
  output logic [IP_W-1:0]         req_adr,
  input  logic                    redirect_v,
  input  logic [IP_W-1:0]         redirect_ip,
  output logic                    out_v,
  input  logic                    out_rdy,
  output logic [INSN_BYTES*8-1:0] out_ir,
  output logic [IP_W-1:0]         out_ip
);
  localparam int              OFF_W = $clog2(LINE_BYTES);
  localparam int              LW    = LINE_BYTES * 8;
  localparam int              IW    = INSN_BYTES * 8;
  localparam logic [IP_W-1:0] AMASK = ~IP_W'(LINE_BYTES - 1);

  logic [IP_W-1:0]  ip, exp_adr, l0_a, l1_a, ip_nx;
  logic             l0_v, l1_v;
  logic [LW-1:0]    l0_d, l1_d;
  logic [OFF_W-1:0] off;
  logic [2*LW-1:0]  sh;
  logic             fits, can_ext, load, retire, acc, l0_keep;

  assign req_adr  = exp_adr;
  assign line_rdy = !l1_v && !redirect_v && !rst_i;
  assign off      = ip[OFF_W-1:0];
  assign fits     = ({1'b0, off} + (OFF_W+1)'(INSN_BYTES)) <= (OFF_W+1)'(LINE_BYTES);
  // slot addresses guard against extracting from a line that does not hold ip
  assign can_ext  = l0_v && (l0_a == (ip & AMASK)) &&
                    (fits || (l1_v && (l1_a == l0_a + IP_W'(LINE_BYTES))));
  assign load     = can_ext && (!out_v || out_rdy);
  assign ip_nx    = ip + IP_W'(INSN_BYTES);
  assign retire   = load && (ip_nx[OFF_W-1:0] < off);
  assign acc      = line_v && line_rdy && ((line_adr & AMASK) == exp_adr);
  assign l0_keep  = retire ? l1_v : l0_v;
  assign sh       = {l1_d, l0_d} >> {off, 3'b000};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ip      <= RST_IP;
      exp_adr <= RST_IP & AMASK;
      l0_v    <= 1'b0;
      l1_v    <= 1'b0;
      out_v   <= 1'b0;
      out_ir  <= '0;
      out_ip  <= '0;
    end else if (redirect_v) begin
      ip      <= redirect_ip;
      exp_adr <= redirect_ip & AMASK;
      l0_v    <= 1'b0;
      l1_v    <= 1'b0;
      out_v   <= 1'b0;
    end else begin
      if (load) begin
        out_v  <= 1'b1;
        out_ir <= sh[IW-1:0];
        out_ip <= ip;
        ip     <= ip_nx;
      end else if (out_v && out_rdy) begin
        out_v  <= 1'b0;
      end
      if (retire) begin
        l0_v <= l1_v;
        l0_d <= l1_d;
        l0_a <= l1_a;
        l1_v <= 1'b0;
      end
      // incoming line lands in whichever slot is free after the shift
      if (acc) begin
        exp_adr <= exp_adr + IP_W'(LINE_BYTES);
        if (!l0_keep) begin
          l0_v <= 1'b1;
          l0_d <= line_data;
          l0_a <= line_adr & AMASK;
        end else begin
          l1_v <= 1'b1;
          l1_d <= line_data;
          l1_a <= line_adr & AMASK;
        end
      end
    end
  end
endmodule

// File: tb/tb_any1_ialign_buf.sv
// Directed bench for any1_ialign_buf: sequential extraction, straddle, backpressure, bad line, redirect, wrap, reset.
module tb_any1_ialign_buf;
  logic         clk_i = 0, rst_i, line_v, line_rdy, redirect_v, out_v, out_rdy;
  logic [31:0]  line_adr, req_adr, redirect_ip, out_ip;
  logic [511:0] line_data;
  logic [39:0]  out_ir;
  int checks = 0, errors = 0;

  any1_ialign_buf dut (
    .clk_i(clk_i), .rst_i(rst_i), .line_v(line_v), .line_rdy(line_rdy),
    .line_adr(line_adr), .line_data(line_data), .req_adr(req_adr),
    .redirect_v(redirect_v), .redirect_ip(redirect_ip), .out_v(out_v),
    .out_rdy(out_rdy), .out_ir(out_ir), .out_ip(out_ip));

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i); #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ov(input string tag);
    for (int k = 0; k < 4 && !out_v; k++) step();
    chk(tag, {63'd0, out_v}, 64'd1);
  endtask

  function automatic logic [511:0] mk(input int base, input logic [7:0] x);
    logic [511:0] d;
    for (int i = 0; i < 64; i++) d[i*8 +: 8] = 8'(base + i) ^ x;
    return d;
  endfunction

  function automatic logic [39:0] insn(input int first, input logic [7:0] x);
    logic [39:0] r;
    for (int j = 0; j < 5; j++) r[j*8 +: 8] = 8'(first + j) ^ x;
    return r;
  endfunction

  initial begin
    rst_i = 1; line_v = 0; line_adr = 0; line_data = '0;
    redirect_v = 0; redirect_ip = 0; out_rdy = 0;
    step(); step();
    chk("rst_line_rdy", {63'd0, line_rdy}, 64'd0);
    chk("rst_out_v", {63'd0, out_v}, 64'd0);
    chk("rst_out_ip", {32'd0, out_ip}, 64'd0);
    chk("rst_out_ir", {24'd0, out_ir}, 64'd0);
    chk("rst_req_adr", {32'd0, req_adr}, 64'hFFFC0100);
    rst_i = 0; #1;
    chk("rdy_after_rst", {63'd0, line_rdy}, 64'd1);

    // first line, sequential extraction
    out_rdy = 1; line_v = 1; line_adr = 32'hFFFC0100; line_data = mk(0, 8'h00);
    step();
    line_v = 0;
    chk("req_adr_adv", {32'd0, req_adr}, 64'hFFFC0140);
    wait_ov("first_out_v");
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("seq_v%0d", i), {63'd0, out_v}, 64'd1);
      chk($sformatf("seq_ip%0d", i), {32'd0, out_ip}, 64'(32'hFFFC0100 + 5*i));
      chk($sformatf("seq_ir%0d", i), {24'd0, out_ir}, {24'd0, insn(5*i, 8'h00)});
      step();
    end
    chk("straddle_wait_v", {63'd0, out_v}, 64'd0);

    // line with wrong address: handshake but dropped
    line_v = 1; line_adr = 32'h00001000; line_data = mk(8'hC0, 8'h00); #1;
    chk("wrong_rdy", {63'd0, line_rdy}, 64'd1);
    step();
    line_v = 0;
    chk("wrong_req_adr", {32'd0, req_adr}, 64'hFFFC0140);
    step();
    chk("wrong_no_out", {63'd0, out_v}, 64'd0);

    // straddle across the line boundary
    line_v = 1; line_adr = 32'hFFFC0140; line_data = mk(8'h40, 8'h00);
    step();
    line_v = 0;
    wait_ov("strad_v");
    chk("strad_ip", {32'd0, out_ip}, 64'hFFFC013C);
    chk("strad_ir", {24'd0, out_ir}, 64'h403F3E3D3C);
    step();
    chk("post_strad_ip", {32'd0, out_ip}, 64'hFFFC0141);
    chk("post_strad_ir", {24'd0, out_ir}, 64'h4544434241);

    // backpressure with both slots full
    out_rdy = 0; line_v = 1; line_adr = 32'hFFFC0180; line_data = mk(8'h80, 8'h00);
    step();
    line_v = 0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp_v%0d", i), {63'd0, out_v}, 64'd1);
      chk($sformatf("bp_ip%0d", i), {32'd0, out_ip}, 64'hFFFC0141);
      chk($sformatf("bp_ir%0d", i), {24'd0, out_ir}, 64'h4544434241);
      chk($sformatf("bp_full%0d", i), {63'd0, line_rdy}, 64'd0);
      step();
    end
    out_rdy = 1;
    step();
    chk("resume_ip0", {32'd0, out_ip}, 64'hFFFC0146);
    chk("resume_ir0", {24'd0, out_ir}, 64'h4A49484746);
    step();
    chk("resume_ip1", {32'd0, out_ip}, 64'hFFFC014B);
    chk("resume_ir1", {24'd0, out_ir}, 64'h4F4E4D4C4B);

    // redirect beats a simultaneous valid line
    redirect_v = 1; redirect_ip = 32'h00002007;
    line_v = 1; line_adr = 32'hFFFC01C0; line_data = mk(8'hC0, 8'h00); #1;
    chk("redir_rdy_low", {63'd0, line_rdy}, 64'd0);
    step();
    redirect_v = 0; line_v = 0; #1;
    chk("redir_out_v", {63'd0, out_v}, 64'd0);
    chk("redir_req_adr", {32'd0, req_adr}, 64'h00002000);
    chk("redir_rdy", {63'd0, line_rdy}, 64'd1);
    step();
    chk("redir_empty", {63'd0, out_v}, 64'd0);
    line_v = 1; line_adr = 32'h00002000; line_data = mk(0, 8'hA5);
    step();
    line_v = 0;
    wait_ov("redir_first_v");
    chk("redir_first_ip", {32'd0, out_ip}, 64'h00002007);
    chk("redir_first_ir", {24'd0, out_ir}, {24'd0, insn(7, 8'hA5)});

    // IP wrap across 2^32
    redirect_v = 1; redirect_ip = 32'hFFFFFFFE;
    step();
    redirect_v = 0;
    chk("wrap_req0", {32'd0, req_adr}, 64'hFFFFFFC0);
    line_v = 1; line_adr = 32'hFFFFFFC0; line_data = mk(0, 8'h00);
    step();
    line_adr = 32'h00000000; line_data = mk(8'h40, 8'h00);
    step();
    line_v = 0;
    chk("wrap_req1", {32'd0, req_adr}, 64'h00000040);
    wait_ov("wrap_v");
    chk("wrap_ip", {32'd0, out_ip}, 64'hFFFFFFFE);
    chk("wrap_ir", {24'd0, out_ir}, 64'h4241403F3E);
    out_rdy = 0; step(); out_rdy = 1; step();
    chk("wrap_next_ip", {32'd0, out_ip}, 64'h00000003);
    chk("wrap_next_ir", {24'd0, out_ir}, 64'h4746454443);

    // reset mid-stream while output is pending
    out_rdy = 0;
    chk("pre_rst_v", {63'd0, out_v}, 64'd1);
    rst_i = 1;
    step();
    chk("mid_rst_v", {63'd0, out_v}, 64'd0);
    chk("mid_rst_req", {32'd0, req_adr}, 64'hFFFC0100);
    rst_i = 0; #1;
    chk("mid_rst_rdy", {63'd0, line_rdy}, 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/any1_ialign_buf.md
Name: any1_ialign_buf

Overview:
- Buffered, parametrised instruction aligner between the I-cache line port and the decode stage.
- Holds up to two consecutive cache lines, so instructions that straddle a line boundary are extracted intact.
- Presents one aligned instruction per cycle through a valid/ready skid register.
- Supports branch redirect (flush) and supplies the next-line fetch address to the fetch unit.

Parameters:
- LINE_BYTES, 64, cache line size in bytes; power of 2, at least 16.
- INSN_BYTES, 5, instruction size in bytes; must be less than LINE_BYTES.
- IP_W, 32, instruction pointer width in bits.
- RST_IP, 32'hFFFC0100, IP loaded at reset.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- line_v  in  1  line_data/line_adr valid.
- line_rdy  out  1  buffer can accept a line this cycle.
- line_adr  in  IP_W  byte address of the line; low log2(LINE_BYTES) bits are ignored.
- line_data  in  LINE_BYTES*8  line contents; byte 0 in bits [7:0].
- req_adr  out  IP_W  line-aligned address of the next line the buffer expects.
- redirect_v  in  1  flush and restart at redirect_ip.
- redirect_ip  in  IP_W  new IP.
- out_v  out  1  out_ir/out_ip valid.
- out_rdy  in  1  consumer accepts the output.
- out_ir  out  INSN_BYTES*8  aligned instruction.
- out_ip  out  IP_W  address of out_ir.

Behaviour:
- State:
  - ip: extraction pointer.
  - Two line slots, L0 (older) and L1, each with a valid bit, data and a line-aligned address.
  - exp_adr: expected next line address; req_adr = exp_adr.
  - Output register: out_v, out_ir, out_ip.
- Reset (rst_i=1 at the clock edge):
  - ip=RST_IP; exp_adr=RST_IP aligned down to the line.
  - L0 and L1 invalid; out_v=0; out_ir=0; out_ip=0.
  - Reset mid-operation discards all buffered lines and any pending output.
- line_rdy = !L1.valid, combinational. It is low during the reset cycle.
- Line accept: a handshake occurs when line_v && line_rdy.
  - If line_adr aligned down != exp_adr, the line is dropped and there is no state change.
  - Otherwise it fills L0 if L0 is invalid, else L1; exp_adr += LINE_BYTES, wrapping modulo 2^IP_W.
- Extract condition: off = ip mod LINE_BYTES. Extraction is possible when L0.valid and either off+INSN_BYTES <= LINE_BYTES or L1.valid.
  - The instruction is bytes off..off+INSN_BYTES-1 of the concatenation {L1.data, L0.data}.
- Output load: when extraction is possible and (!out_v || out_rdy):
  - out_ir = the extracted instruction; out_ip = ip; out_v=1.
  - ip += INSN_BYTES.
  - If the new ip is at or beyond L0's range (new off < old off, or a wrap), L1 shifts into L0 and L1 becomes invalid. An acceptance in the same cycle lands in the freed slot (L1 if L0 is still valid after the shift).
- If out_rdy && out_v and no extraction is possible, out_v drops to 0.
- Latency: a line accepted in cycle N produces out_v=1 in cycle N+1 at the earliest.
- Throughput: one instruction per cycle while lines keep up.
- Redirect: redirect_v has priority over all other events in the same cycle.
  - ip=redirect_ip; exp_adr=redirect_ip aligned down.
  - L0 and L1 invalid; out_v=0.
  - A line presented in the same cycle is not accepted; line_rdy is forced low while redirect_v=1.
- Stall: while out_v && !out_rdy, out_ir, out_ip and out_v hold stable. Line acceptance continues while a slot is free.
- Full: with both slots valid, line_rdy=0. The buffer never overwrites a valid slot.
- IP wrap: ip and exp_adr wrap modulo 2^IP_W. L1 follows L0 across the wrap.

Test Plan:
- Reset, then feed the line at 0xFFFC0100 (bytes 0..63 = 0x00..0x3F), out_rdy=1:
  - out_v rises 1 cycle after acceptance.
  - Outputs are out_ip=0xFFFC0100, ir=0x0403020100; then 0xFFFC0105, ir=0x0908070605; and so on.
  - After 12 instructions, out_v=0 (0xFFFC013C straddles the line boundary and L1 is empty).
- Straddle:
  - Add the next line at 0xFFFC0140 (bytes 0x40..0x7F).
  - Expect out_ip=0xFFFC013C, ir=0x403F3E3D3C.
  - L0 is then retired; the next ip is 0xFFFC0141.
- Backpressure: hold out_rdy=0 for 5 cycles with both lines buffered.
  - out_ir/out_ip stay stable and line_rdy=0.
  - Releasing out_rdy resumes the sequence with no instruction lost or duplicated.
- Wrong line: present line_adr=0x00001000 while exp_adr=0xFFFC0140 → handshake occurs, line is dropped, and req_adr stays 0xFFFC0140.
- Redirect with simultaneous line_v and out_rdy: redirect_ip=0x00002007 → next cycle out_v=0, both slots empty, req_adr=0x00002000.
  - Feed that line; the first output is out_ip=0x00002007.
- Reset mid-stream with out_v=1 → next cycle out_v=0, req_adr=0xFFFC0100, line_rdy=1.
